drm_activator_stream_arbiter: RTL and testbench
===============================================

Name: drm_activator_stream_arbiter

Overview:
Shares one DRM Controller AXI4-Stream channel pair between NUM_PORTS DRM IP activators. Arbitration is packet-level round-robin on the upstream (activator to DRM) direction. The next downstream (DRM to activator) packet is routed back to the activator that sent the request. The block sits between the DRM Controller stream ports and the activator instances in the top-level wrapper.

Parameters:
NUM_PORTS, 4, number of activator ports (2..16)
RESP_TIMEOUT, 1024, cycles to wait for the first response beat before abandoning the transaction (>=2)
IDW, derived max(1,$clog2(NUM_PORTS)), width of the grant index; localparam, not overridable

Ports:
drm_aclk  in  1  clock for all logic
drm_arstn  in  1  asynchronous active-low reset
act_send_tvalid  in  NUM_PORTS  per-activator request stream valid
act_send_tready  out  NUM_PORTS  per-activator request stream ready
act_send_tdata  in  32*NUM_PORTS  request data; port i occupies bits [32i+31:32i]
act_send_tlast  in  NUM_PORTS  request end of packet
act_recv_tvalid  out  NUM_PORTS  per-activator response valid
act_recv_tready  in  NUM_PORTS  per-activator response ready
act_recv_tdata  out  32*NUM_PORTS  response data, same packing as act_send_tdata
act_recv_tlast  out  NUM_PORTS  response end of packet
uip_to_drm_tvalid  out  1  merged request to the DRM Controller
uip_to_drm_tready  in  1  DRM Controller ready
uip_to_drm_tdata  out  32  merged request data
uip_to_drm_tlast  out  1  merged request end of packet
drm_to_uip_tvalid  in  1  response from the DRM Controller
drm_to_uip_tready  out  1  response ready
drm_to_uip_tdata  in  32  response data
drm_to_uip_tlast  in  1  response end of packet
grant_id  out  IDW  currently owning port
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse when a response times out
stray_drop  out  1  one-cycle pulse per discarded unsolicited response beat

Behaviour:
- Reset values:
  - state=IDLE, grant_id=0, last_grant=NUM_PORTS-1 (so port 0 has first priority), wait counter=0.
  - All tvalid/tready outputs 0; busy=0; timeout_err=0; stray_drop=0.
- Datapath: no buffering. Granted-port signals are combinational pass-through, so data latency is zero.
  - Ungranted ports: act_send_tready=0, act_recv_tvalid=0.
  - act_recv_tdata of every port = drm_to_uip_tdata; act_recv_tlast of every port = drm_to_uip_tlast. Only the owner's tvalid qualifies them.
- IDLE:
  - Every act_send_tready=0 and uip_to_drm_tvalid=0.
  - drm_to_uip_tready=1. Any handshaked beat in IDLE is discarded and pulses stray_drop next cycle.
  - If any act_send_tvalid is high, grant the first requesting port searching upward from last_grant+1 modulo NUM_PORTS. Register grant_id; go to FWD_REQ. One cycle of arbitration latency.
- FWD_REQ:
  - uip_to_drm_tvalid/tdata/tlast = granted port's signals; act_send_tready[grant] = uip_to_drm_tready.
  - drm_to_uip_tready=1 and beats are discarded with a stray_drop pulse.
  - On a handshake with tlast=1: last_grant<=grant_id, clear wait counter, go to WAIT_RSP.
  - Requests from other ports are held off until the current transaction returns to IDLE.
- WAIT_RSP:
  - act_recv_tvalid[grant] = drm_to_uip_tvalid; drm_to_uip_tready = act_recv_tready[grant].
  - Counter increments each cycle with no handshake.
  - On the first handshake: if tlast=1 go to IDLE, else go to FWD_RSP.
  - If no handshake and counter == RESP_TIMEOUT-1: go to IDLE and pulse timeout_err for one cycle.
- FWD_RSP: same routing as WAIT_RSP, with no timeout. On a handshake with tlast=1, go to IDLE.
- Simultaneous requests are resolved only by the round-robin order. A timed-out port still counts as served, so last_grant advances.
- The arbiter never drops or reorders request beats. A requester that deasserts tvalid mid-packet just stalls FWD_REQ.
- Reset asserted mid-packet: immediate return to reset values, with no completion of the partial packet. Integrators must reset the DRM Controller together with this block.

Test Plan:
- Single request: port 2 sends a 3-beat packet (0xA1,0xA2,0xA3 with tlast) and the DRM returns a 2-beat response → uip_to_drm carries 0xA1..0xA3 starting 1 cycle after tvalid; the response reaches only act_recv port 2; busy falls the cycle after the response tlast.
- Round-robin: ports 0,1,3 request continuously from reset, each with a 1-beat request and 1-beat response → grant order 0,1,3,0,1,3; port 2 never granted.
- Backpressure: uip_to_drm_tready toggles 1,0,1,0 during a 4-beat request, and act_recv_tready=0 for 5 cycles during a response → no beat lost or duplicated; drm_to_uip_tready mirrors act_recv_tready of the owner.
- Timeout: RESP_TIMEOUT=16, request sent with no response → timeout_err pulses exactly 16 cycles after entering WAIT_RSP; the next request from the same port is not granted ahead of other pending ports.
- Stray response: a 2-beat drm_to_uip packet arrives in IDLE → both beats accepted, two stray_drop pulses, every act_recv_tvalid stays 0.
- Reset mid-request: drm_arstn is pulsed low during beat 2 of a 4-beat packet from port 1 → all outputs return to reset values asynchronously; after release, port 0 wins when ports 0 and 1 both request.

Source files
------------

// File: rtl/drm_activator_stream_arbiter.sv
// ---------------------------------------------------------------------------
// drm_activator_stream_arbiter
//
// Shares one DRM Controller AXI4-Stream channel pair between NUM_PORTS DRM IP
// activators. Requests (activator -> DRM) are arbitrated packet by packet in
// round-robin order. The next response packet (DRM -> activator) is routed
// back to the activator that sent the request. There is no buffering: the
// granted port is a combinational pass-through.
//
// Ports:
//   drm_aclk, drm_arstn       clock, asynchronous active-low reset
//   act_send_*                per-activator request streams (32-bit lanes)
//   act_recv_*                per-activator response streams (32-bit lanes)
//   uip_to_drm_*              merged request stream to the DRM Controller
//   drm_to_uip_*              response stream from the DRM Controller
//   grant_id                  index of the port currently owning the channel
//   busy                      high whenever a transaction is in progress
//   timeout_err               one-cycle pulse when a response never started
//   stray_drop                one-cycle pulse per discarded unsolicited beat
// ---------------------------------------------------------------------------
module drm_activator_stream_arbiter #(
    parameter  int unsigned NUM_PORTS    = 4,
    parameter  int unsigned RESP_TIMEOUT = 1024,
    localparam int unsigned IDW          = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    drm_aclk,
    input  logic                    drm_arstn,

    input  logic [NUM_PORTS-1:0]    act_send_tvalid,
    output logic [NUM_PORTS-1:0]    act_send_tready,
    input  logic [32*NUM_PORTS-1:0] act_send_tdata,
    input  logic [NUM_PORTS-1:0]    act_send_tlast,

    output logic [NUM_PORTS-1:0]    act_recv_tvalid,
    input  logic [NUM_PORTS-1:0]    act_recv_tready,
    output logic [32*NUM_PORTS-1:0] act_recv_tdata,
    output logic [NUM_PORTS-1:0]    act_recv_tlast,

    output logic                    uip_to_drm_tvalid,
    input  logic                    uip_to_drm_tready,
    output logic [31:0]             uip_to_drm_tdata,
    output logic                    uip_to_drm_tlast,

    input  logic                    drm_to_uip_tvalid,
    output logic                    drm_to_uip_tready,
    input  logic [31:0]             drm_to_uip_tdata,
    input  logic                    drm_to_uip_tlast,

    output logic [IDW-1:0]          grant_id,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    stray_drop
);

    localparam int unsigned CW = $clog2(RESP_TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFwdReq,
        StWaitRsp,
        StFwdRsp
    } state_t;

    state_t          state;
    logic [IDW-1:0]  last_grant;
    logic [CW-1:0]   wait_cnt;

    // Round-robin pick
    logic            arb_found;
    logic [IDW-1:0]  arb_idx;
    int              cand;
    logic [IDW-1:0]  cand_idx;

    // Granted-port view
    logic            sel_valid;
    logic [31:0]     sel_data;
    logic            sel_last;
    logic            sel_rready;

    logic            req_hs;
    logic            rsp_hs;

    // First requester searching upward from last_grant+1, wrapping at NUM_PORTS.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= int'(NUM_PORTS); i++) begin
            cand     = (int'(last_grant) + i) % int'(NUM_PORTS);
            cand_idx = IDW'(cand);
            if (!arb_found && act_send_tvalid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_valid  = 1'b0;
        sel_data   = '0;
        sel_last   = 1'b0;
        sel_rready = 1'b0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (IDW'(p) == grant_id) begin
                sel_valid  = act_send_tvalid[p];
                sel_data   = act_send_tdata[32*p +: 32];
                sel_last   = act_send_tlast[p];
                sel_rready = act_recv_tready[p];
            end
        end
    end

    always_comb begin
        act_send_tready   = '0;
        act_recv_tvalid   = '0;
        uip_to_drm_tvalid = 1'b0;
        uip_to_drm_tdata  = '0;
        uip_to_drm_tlast  = 1'b0;
        drm_to_uip_tready = 1'b0;
        // Response data fans out to every port; only the owner's tvalid qualifies it.
        act_recv_tdata    = {NUM_PORTS{drm_to_uip_tdata}};
        act_recv_tlast    = {NUM_PORTS{drm_to_uip_tlast}};
        unique case (state)
            StIdle: begin
                // Held low while in reset so every ready/valid output reads 0.
                drm_to_uip_tready = drm_arstn;
            end
            StFwdReq: begin
                uip_to_drm_tvalid         = sel_valid;
                uip_to_drm_tdata          = sel_data;
                uip_to_drm_tlast          = sel_last;
                act_send_tready[grant_id] = uip_to_drm_tready;
                drm_to_uip_tready         = 1'b1;
            end
            StWaitRsp, StFwdRsp: begin
                act_recv_tvalid[grant_id] = drm_to_uip_tvalid;
                drm_to_uip_tready         = sel_rready;
            end
            default: ;
        endcase
    end

    assign req_hs = uip_to_drm_tvalid & uip_to_drm_tready;
    assign rsp_hs = drm_to_uip_tvalid & drm_to_uip_tready;
    assign busy   = (state != StIdle);

    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            state       <= StIdle;
            grant_id    <= '0;
            last_grant  <= IDW'(NUM_PORTS - 1);
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            stray_drop  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            stray_drop  <= 1'b0;
            unique case (state)
                StIdle: begin
                    stray_drop <= rsp_hs;
                    if (arb_found) begin
                        grant_id <= arb_idx;
                        state    <= StFwdReq;
                    end
                end
                StFwdReq: begin
                    stray_drop <= rsp_hs;
                    if (req_hs && sel_last) begin
                        last_grant <= grant_id;
                        wait_cnt   <= '0;
                        state      <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (rsp_hs) begin
                        state <= drm_to_uip_tlast ? StIdle : StFwdRsp;
                    end else if (wait_cnt == TMAX) begin
                        // Port still counts as served: last_grant was already advanced.
                        state       <= StIdle;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StFwdRsp: begin
                    if (rsp_hs && drm_to_uip_tlast) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_drm_activator_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_drm_activator_stream_arbiter
//
// Directed bench for drm_activator_stream_arbiter with 4 ports and a 16-cycle
// response timeout. Inputs change 1 time unit after the rising edge; outputs
// are checked 1 time unit after that.
// ---------------------------------------------------------------------------
module tb_drm_activator_stream_arbiter;

    localparam int unsigned NP  = 4;
    localparam int unsigned IDW = 2;

    logic              drm_aclk;
    logic              drm_arstn;
    logic [NP-1:0]     act_send_tvalid;
    logic [NP-1:0]     act_send_tready;
    logic [32*NP-1:0]  act_send_tdata;
    logic [NP-1:0]     act_send_tlast;
    logic [NP-1:0]     act_recv_tvalid;
    logic [NP-1:0]     act_recv_tready;
    logic [32*NP-1:0]  act_recv_tdata;
    logic [NP-1:0]     act_recv_tlast;
    logic              uip_to_drm_tvalid;
    logic              uip_to_drm_tready;
    logic [31:0]       uip_to_drm_tdata;
    logic              uip_to_drm_tlast;
    logic              drm_to_uip_tvalid;
    logic              drm_to_uip_tready;
    logic [31:0]       drm_to_uip_tdata;
    logic              drm_to_uip_tlast;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic              timeout_err;
    logic              stray_drop;

    int n_vec;
    int n_err;

    drm_activator_stream_arbiter #(
        .NUM_PORTS    (NP),
        .RESP_TIMEOUT (16)
    ) dut (
        .drm_aclk          (drm_aclk),
        .drm_arstn         (drm_arstn),
        .act_send_tvalid   (act_send_tvalid),
        .act_send_tready   (act_send_tready),
        .act_send_tdata    (act_send_tdata),
        .act_send_tlast    (act_send_tlast),
        .act_recv_tvalid   (act_recv_tvalid),
        .act_recv_tready   (act_recv_tready),
        .act_recv_tdata    (act_recv_tdata),
        .act_recv_tlast    (act_recv_tlast),
        .uip_to_drm_tvalid (uip_to_drm_tvalid),
        .uip_to_drm_tready (uip_to_drm_tready),
        .uip_to_drm_tdata  (uip_to_drm_tdata),
        .uip_to_drm_tlast  (uip_to_drm_tlast),
        .drm_to_uip_tvalid (drm_to_uip_tvalid),
        .drm_to_uip_tready (drm_to_uip_tready),
        .drm_to_uip_tdata  (drm_to_uip_tdata),
        .drm_to_uip_tlast  (drm_to_uip_tlast),
        .grant_id          (grant_id),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .stray_drop        (stray_drop)
    );

    initial begin
        drm_aclk = 1'b0;
        forever #5 drm_aclk = ~drm_aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge drm_aclk);
        #1;
    endtask

    task automatic set_send(input int p, input logic v, input logic [31:0] d, input logic l);
        act_send_tvalid[p]          = v;
        act_send_tdata[32*p +: 32]  = d;
        act_send_tlast[p]           = l;
    endtask

    task automatic set_rsp(input logic v, input logic [31:0] d, input logic l);
        drm_to_uip_tvalid = v;
        drm_to_uip_tdata  = d;
        drm_to_uip_tlast  = l;
    endtask

    logic [31:0] bdat [4];
    int          rr_exp [6];
    int          idx;
    int          c;
    logic        tr;

    initial begin
        n_vec = 0;
        n_err = 0;
        bdat   = '{32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3, 32'h0000_00B4};
        rr_exp = '{0, 1, 3, 0, 1, 3};

        drm_arstn         = 1'b1;
        act_send_tvalid   = '0;
        act_send_tdata    = '0;
        act_send_tlast    = '0;
        act_recv_tready   = '1;
        uip_to_drm_tready = 1'b1;
        set_rsp(1'b0, 32'h0, 1'b0);
        #1 drm_arstn = 1'b0;
        #1;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_uip_tvalid", 32'(uip_to_drm_tvalid), 32'd0);
        chk("rst_drm_tready", 32'(drm_to_uip_tready), 32'd0);
        chk("rst_send_tready", 32'(act_send_tready), 32'd0);
        chk("rst_recv_tvalid", 32'(act_recv_tvalid), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_stray", 32'(stray_drop), 32'd0);
        cyc();
        cyc();
        drm_arstn = 1'b1;
        #1;
        chk("idle_drm_tready", 32'(drm_to_uip_tready), 32'd1);

        // Single request from port 2, 3 beats, 2-beat response
        set_send(2, 1'b1, 32'hA1, 1'b0);
        #1;
        chk("sr_arb_latency", 32'(uip_to_drm_tvalid), 32'd0);
        cyc();
        chk("sr_grant", 32'(grant_id), 32'd2);
        chk("sr_busy", 32'(busy), 32'd1);
        chk("sr_uip_tvalid", 32'(uip_to_drm_tvalid), 32'd1);
        chk("sr_beat1", uip_to_drm_tdata, 32'hA1);
        chk("sr_send_tready", 32'(act_send_tready), 32'b0100);
        cyc();
        set_send(2, 1'b1, 32'hA2, 1'b0);
        #1;
        chk("sr_beat2", uip_to_drm_tdata, 32'hA2);
        cyc();
        set_send(2, 1'b1, 32'hA3, 1'b1);
        #1;
        chk("sr_beat3", uip_to_drm_tdata, 32'hA3);
        chk("sr_beat3_last", 32'(uip_to_drm_tlast), 32'd1);
        cyc();
        set_send(2, 1'b0, 32'h0, 1'b0);
        set_rsp(1'b1, 32'h5100_0001, 1'b0);
        #1;
        chk("sr_wait_uip_tvalid", 32'(uip_to_drm_tvalid), 32'd0);
        chk("sr_rsp1_route", 32'(act_recv_tvalid), 32'b0100);
        chk("sr_rsp1_data", act_recv_tdata[64 +: 32], 32'h5100_0001);
        chk("sr_rsp1_tready", 32'(drm_to_uip_tready), 32'd1);
        cyc();
        set_rsp(1'b1, 32'h5100_0002, 1'b1);
        #1;
        chk("sr_rsp2_route", 32'(act_recv_tvalid), 32'b0100);
        chk("sr_rsp2_last", 32'(act_recv_tlast[2]), 32'd1);
        chk("sr_busy_last", 32'(busy), 32'd1);
        cyc();
        set_rsp(1'b0, 32'h0, 1'b0);
        #1;
        chk("sr_busy_fall", 32'(busy), 32'd0);

        // Round-robin from a fresh reset: ports 0,1,3 request continuously
        drm_arstn = 1'b0;
        cyc();
        drm_arstn = 1'b1;
        set_send(0, 1'b1, 32'hC0, 1'b1);
        set_send(1, 1'b1, 32'hC1, 1'b1);
        set_send(3, 1'b1, 32'hC3, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rr_grant", 32'(grant_id), 32'(rr_exp[k]));
            chk("rr_data", uip_to_drm_tdata, 32'hC0 + 32'(rr_exp[k]));
            cyc();
            set_rsp(1'b1, 32'hD0 + 32'(k), 1'b1);
            #1;
            chk("rr_rsp_route", 32'(act_recv_tvalid), 32'd1 << rr_exp[k]);
            cyc();
            set_rsp(1'b0, 32'h0, 1'b0);
        end
        set_send(0, 1'b0, 32'h0, 1'b0);
        set_send(1, 1'b0, 32'h0, 1'b0);
        set_send(3, 1'b0, 32'h0, 1'b0);

        // Backpressure: port 1, 4 beats, tready alternating 1,0,...
        set_send(1, 1'b1, bdat[0], 1'b0);
        cyc();
        chk("bp_grant", 32'(grant_id), 32'd1);
        idx = 0;
        c   = 0;
        while (idx < 4 && c < 20) begin
            tr = (c % 2 == 0);
            uip_to_drm_tready = tr;
            set_send(1, 1'b1, bdat[idx], (idx == 3));
            #1;
            chk("bp_data", uip_to_drm_tdata, bdat[idx]);
            chk("bp_send_tready", 32'(act_send_tready), tr ? 32'b0010 : 32'b0000);
            cyc();
            if (tr) idx++;
            c++;
        end
        chk("bp_cycles", 32'(c), 32'd7);
        uip_to_drm_tready = 1'b1;
        set_send(1, 1'b0, 32'h0, 1'b0);
        act_recv_tready[1] = 1'b0;
        set_rsp(1'b1, 32'hE1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_recv_hold_valid", 32'(act_recv_tvalid), 32'b0010);
            chk("bp_drm_tready_low", 32'(drm_to_uip_tready), 32'd0);
            cyc();
        end
        act_recv_tready[1] = 1'b1;
        #1;
        chk("bp_drm_tready_high", 32'(drm_to_uip_tready), 32'd1);
        chk("bp_rsp1_data", act_recv_tdata[32 +: 32], 32'hE1);
        cyc();
        set_rsp(1'b1, 32'hE2, 1'b1);
        #1;
        chk("bp_rsp2_route", 32'(act_recv_tvalid), 32'b0010);
        cyc();
        set_rsp(1'b0, 32'h0, 1'b0);
        #1;
        chk("bp_done_busy", 32'(busy), 32'd0);
        chk("bp_no_timeout", 32'(timeout_err), 32'd0);

        // Timeout: port 0 request, no response
        set_send(0, 1'b1, 32'hF0, 1'b1);
        cyc();
        chk("to_grant", 32'(grant_id), 32'd0);
        cyc();
        set_send(0, 1'b1, 32'hF1, 1'b1);
        set_send(2, 1'b1, 32'hF2, 1'b1);
        #1;
        chk("to_wait_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk("to_no_pulse_yet", 32'(timeout_err), 32'd0);
        end
        cyc();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        cyc();
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        chk("to_next_grant", 32'(grant_id), 32'd2);
        cyc();
        set_send(2, 1'b0, 32'h0, 1'b0);
        set_rsp(1'b1, 32'h77, 1'b1);
        #1;
        chk("to_p2_rsp_route", 32'(act_recv_tvalid), 32'b0100);
        cyc();
        set_rsp(1'b0, 32'h0, 1'b0);
        cyc();
        chk("to_p0_regrant", 32'(grant_id), 32'd0);
        chk("to_p0_data", uip_to_drm_tdata, 32'hF1);
        cyc();
        set_send(0, 1'b0, 32'h0, 1'b0);
        set_rsp(1'b1, 32'h78, 1'b1);
        cyc();
        set_rsp(1'b0, 32'h0, 1'b0);

        // Stray 2-beat response in IDLE
        set_rsp(1'b1, 32'h5A, 1'b0);
        #1;
        chk("st_tready", 32'(drm_to_uip_tready), 32'd1);
        chk("st_recv_valid1", 32'(act_recv_tvalid), 32'd0);
        cyc();
        chk("st_pulse1", 32'(stray_drop), 32'd1);
        set_rsp(1'b1, 32'h5B, 1'b1);
        #1;
        chk("st_recv_valid2", 32'(act_recv_tvalid), 32'd0);
        cyc();
        chk("st_pulse2", 32'(stray_drop), 32'd1);
        set_rsp(1'b0, 32'h0, 1'b0);
        cyc();
        chk("st_pulse_end", 32'(stray_drop), 32'd0);
        chk("st_busy", 32'(busy), 32'd0);

        // Reset during beat 2 of a 4-beat packet from port 1
        set_send(1, 1'b1, 32'h61, 1'b0);
        cyc();
        chk("mr_grant", 32'(grant_id), 32'd1);
        cyc();
        set_send(1, 1'b1, 32'h62, 1'b0);
        #1;
        chk("mr_beat2", uip_to_drm_tdata, 32'h62);
        drm_arstn = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_grant_rst", 32'(grant_id), 32'd0);
        chk("mr_uip_tvalid", 32'(uip_to_drm_tvalid), 32'd0);
        chk("mr_send_tready", 32'(act_send_tready), 32'd0);
        chk("mr_drm_tready", 32'(drm_to_uip_tready), 32'd0);
        cyc();
        drm_arstn = 1'b1;
        set_send(0, 1'b1, 32'h60, 1'b1);
        #1;
        chk("mr_idle_after", 32'(busy), 32'd0);
        cyc();
        chk("mr_port0_wins", 32'(grant_id), 32'd0);
        chk("mr_port0_data", uip_to_drm_tdata, 32'h60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
